decode_ctrl: RTL and testbench

DECODE_CTRL -- requirements
Module: decode_ctrl

---
 rtl/decode_ctrl_pkg.sv | 49 ++++
 rtl/decode_ctrl_extend.sv | 35 +++
 rtl/decode_ctrl.sv | 115 +++++++++++
 tb/tb_decode_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_ctrl_pkg.sv
// Shared types for the decode stage: scalar aliases, op classes, the
// queue entry struct, occupancy encoding and the load-use helper.
package decode_ctrl_pkg;

    typedef logic [31:0] u32;
    typedef logic [63:0] u64;
    typedef u64          word_t;

    // Op class produced by the combinational decoder ahead of this block.
    typedef enum logic [3:0] {
        OP_NONE   = 4'd0,
        OP_ALU    = 4'd1,
        OP_ALUI   = 4'd2,
        OP_LOAD   = 4'd3,
        OP_STORE  = 4'd4,
        OP_BRANCH = 4'd5,
        OP_LUI    = 4'd6,
        OP_AUIPC  = 4'd7,
        OP_JAL    = 4'd8,
        OP_JALR   = 4'd9,
        OP_SYSTEM = 4'd10
    } decode_op_t;

    localparam int OP_NUM = 11;
    localparam int DEPTH  = 2;

    // One held instruction.
    typedef struct packed {
        u32         instr;
        u64         pc;
        decode_op_t op;
    } entry_t;

    // Queue occupancy; the encoding doubles as the entry count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } occ_t;

    // A load in execute blocks the head if it writes either source field.
    // rs2 is compared for every op, so non-R ops may stall conservatively.
    function automatic logic load_use(input u32 instr, input logic ld_valid,
                                      input logic [4:0] rd);
        return ld_valid && (rd != 5'd0) &&
               ((rd == instr[19:15]) || (rd == instr[24:20]));
    endfunction

endpackage

// File: rtl/decode_ctrl_extend.sv
// Immediate extraction and sign extension for the head entry.
module decode_ctrl_extend
    import decode_ctrl_pkg::*;
(
    input  u32         instr_i,
    input  decode_op_t op_i,
    output word_t      imm_o
);

    // Opcode bits are not needed: the op class already selects the format.
    logic unused_opcode;
    assign unused_opcode = ^instr_i[6:0];

    // Select the immediate format from the op class; other ops give zero.
    always_comb begin
        imm_o = '0;
        case (op_i)
            OP_ALUI, OP_LOAD, OP_JALR:
                imm_o = {{52{instr_i[31]}}, instr_i[31:20]};
            OP_STORE:
                imm_o = {{52{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
            OP_BRANCH:
                imm_o = {{51{instr_i[31]}}, instr_i[31], instr_i[7],
                         instr_i[30:25], instr_i[11:8], 1'b0};
            OP_LUI, OP_AUIPC:
                imm_o = {{32{instr_i[31]}}, instr_i[31:12], 12'b0};
            OP_JAL:
                imm_o = {{43{instr_i[31]}}, instr_i[31], instr_i[19:12],
                         instr_i[20], instr_i[30:21], 1'b0};
            default:
                imm_o = '0;
        endcase
    end

endmodule

// File: rtl/decode_ctrl.sv
// Two-entry decode queue between fetch and execute with load-use stall
// detection on the head entry, flush and a saturating stall counter.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. f_ready depends only on registered state (and reset); d_valid
// drops combinationally on a load-use hazard or flush. While d_valid is high
// and d_ready low the head fields do not change.
module decode_ctrl
    import decode_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        f_valid,
    output logic        f_ready,
    input  u32          f_instr,
    input  u64          f_pc,
    input  decode_op_t  f_op,
    output logic        d_valid,
    input  logic        d_ready,
    output u32          d_instr,
    output u64          d_pc,
    output decode_op_t  d_op,
    output word_t       d_imm,
    input  logic        ex_load_valid,
    input  logic [4:0]  ex_rd,
    input  logic        flush,
    output logic [31:0] stall_cnt,
    output occ_t        state_dbg
);

    occ_t        count_q;
    logic        head_q;
    entry_t      slot_q [DEPTH];
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    entry_t head_e;
    logic   tail;
    logic   hazard;
    logic   enq;
    logic   deq;
    logic   stall_inc;

    assign head_e    = slot_q[head_q];
    assign tail      = head_q ^ count_q[0];
    assign hazard    = load_use(head_e.instr, ex_load_valid, ex_rd);

    // Gating with reset_n keeps fetch blocked while reset is held.
    assign f_ready   = reset_n & (count_q != ST_FULL);
    assign d_valid   = (count_q != ST_EMPTY) & ~hazard & ~flush;
    assign enq       = f_valid & f_ready & ~flush;
    assign deq       = d_valid & d_ready;
    assign stall_inc = (count_q != ST_EMPTY) & hazard & ~flush;

    assign d_instr   = head_e.instr;
    assign d_pc      = head_e.pc;
    assign d_op      = head_e.op;
    assign stall_cnt = stall_cnt_q;
    assign state_dbg = count_q;

    decode_ctrl_extend u_extend (
        .instr_i (head_e.instr),
        .op_i    (head_e.op),
        .imm_o   (d_imm)
    );

    // Occupancy FSM: flush empties the queue; enq+deq together keep count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= ST_EMPTY;
            head_q  <= 1'b0;
        end else if (flush) begin
            count_q <= ST_EMPTY;
            head_q  <= 1'b0;
        end else begin
            if (deq) begin
                head_q <= ~head_q;
            end
            case ({enq, deq})
                2'b10:   count_q <= (count_q == ST_EMPTY) ? ST_ONE : ST_FULL;
                2'b01:   count_q <= (count_q == ST_FULL) ? ST_ONE : ST_EMPTY;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage: accepted fetch data lands in the tail slot.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
        end else if (enq) begin
            slot_q[tail] <= '{instr: f_instr, pc: f_pc, op: f_op};
        end
    end

    // Stall counter next value, saturating at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_inc && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    // Stall counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_decode_ctrl.sv
// Bench for decode_ctrl: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_decode_ctrl;
    import decode_ctrl_pkg::*;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        f_valid = 1'b0;
    u32          f_instr = '0;
    u64          f_pc = '0;
    decode_op_t  f_op = OP_NONE;
    logic        d_ready = 1'b0;
    logic        ex_load_valid = 1'b0;
    logic [4:0]  ex_rd = '0;
    logic        flush = 1'b0;
    logic        f_ready;
    logic        d_valid;
    u32          d_instr;
    u64          d_pc;
    decode_op_t  d_op;
    word_t       d_imm;
    logic [31:0] stall_cnt;
    occ_t        state_dbg;

    always #5 clk = ~clk;

    decode_ctrl dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .f_valid       (f_valid),
        .f_ready       (f_ready),
        .f_instr       (f_instr),
        .f_pc          (f_pc),
        .f_op          (f_op),
        .d_valid       (d_valid),
        .d_ready       (d_ready),
        .d_instr       (d_instr),
        .d_pc          (d_pc),
        .d_op          (d_op),
        .d_imm         (d_imm),
        .ex_load_valid (ex_load_valid),
        .ex_rd         (ex_rd),
        .flush         (flush),
        .stall_cnt     (stall_cnt),
        .state_dbg     (state_dbg)
    );

    // ---------------- scoreboard state ----------------
    int          n_checks = 0;
    int          n_fail = 0;
    entry_t      exp_q[$];
    logic [31:0] exp_stall = '0;

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic logic m_hazard();
        u32 ins;
        if (exp_q.size() == 0) return 1'b0;
        ins = exp_q[0].instr;
        return ex_load_valid && (ex_rd != 5'd0) &&
               (ex_rd == ins[19:15] || ex_rd == ins[24:20]);
    endfunction

    // Immediate value as plain integer arithmetic: gather the field bits,
    // then subtract 2^bits when the top bit is set.
    function automatic logic [63:0] m_imm(input u32 ins, input decode_op_t op);
        longint raw;
        int     bits;
        raw  = 0;
        bits = 0;
        case (op)
            OP_ALUI, OP_LOAD, OP_JALR: begin
                raw = longint'(ins[31:20]); bits = 12;
            end
            OP_STORE: begin
                raw = longint'({ins[31:25], ins[11:7]}); bits = 12;
            end
            OP_BRANCH: begin
                raw = longint'({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}); bits = 13;
            end
            OP_LUI, OP_AUIPC: begin
                raw = longint'({ins[31:12], 12'b0}); bits = 32;
            end
            OP_JAL: begin
                raw = longint'({ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}); bits = 21;
            end
            default: bits = 0;
        endcase
        if (bits != 0 && raw >= (longint'(1) << (bits - 1)))
            raw = raw - (longint'(1) << bits);
        return 64'(raw);
    endfunction

    // Asynchronous reset empties the model at once.
    initial begin
        forever begin
            @(negedge reset_n);
            exp_q.delete();
            exp_stall = '0;
        end
    end

    // Model update on each rising edge from the inputs held across it.
    initial begin
        int   sz;
        logic hz;
        logic dv;
        entry_t e;
        forever begin
            @(posedge clk);
            if (reset_n) begin
                sz = exp_q.size();
                hz = m_hazard();
                dv = (sz > 0) && !hz && !flush;
                if (sz > 0 && hz && !flush && exp_stall != 32'hFFFF_FFFF)
                    exp_stall = exp_stall + 32'd1;
                if (flush) begin
                    exp_q.delete();
                end else begin
                    if (dv && d_ready) void'(exp_q.pop_front());
                    if (f_valid && sz < 2) begin
                        e.instr = f_instr; e.pc = f_pc; e.op = f_op;
                        exp_q.push_back(e);
                    end
                end
            end
        end
    end

    // Compare process: every falling edge, DUT versus model.
    initial begin
        int   sz;
        logic hz;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                check("rst_d_valid", d_valid, 0);
                check("rst_f_ready", f_ready, 0);
                check("rst_stall", stall_cnt, 0);
                check("rst_state", state_dbg, 0);
            end else begin
                sz = exp_q.size();
                hz = m_hazard();
                check("f_ready", f_ready, (sz < 2));
                check("d_valid", d_valid, (sz > 0) && !hz && !flush);
                check("occupancy", state_dbg, sz);
                check("stall_cnt", stall_cnt, exp_stall);
                if (sz > 0) begin
                    check("d_instr", d_instr, exp_q[0].instr);
                    check("d_pc", d_pc, exp_q[0].pc);
                    check("d_op", d_op, exp_q[0].op);
                    check("d_imm", d_imm, m_imm(exp_q[0].instr, exp_q[0].op));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input u32 ins, input u64 pc, input decode_op_t op);
        f_valid = 1'b1;
        f_instr = ins;
        f_pc    = pc;
        f_op    = op;
    endtask

    task automatic rand_inputs();
        u32 ins;
        ins = $urandom;
        ins[19:15] = 5'($urandom_range(0, 7));
        ins[24:20] = 5'($urandom_range(0, 7));
        f_valid       = 1'($urandom_range(0, 1));
        f_instr       = ins;
        f_pc          = {$urandom, $urandom};
        f_op          = decode_op_t'($urandom_range(0, OP_NUM - 1));
        d_ready       = ($urandom_range(0, 3) != 0);
        ex_load_valid = ($urandom_range(0, 3) == 0);
        ex_rd         = 5'($urandom_range(0, 7));
        flush         = ($urandom_range(0, 19) == 0);
    endtask

    // ---------------- stimulus ----------------
    u32 addi_i [3];
    u64 addi_pc [3];
    u64 addi_imm [3];

    initial begin
        addi_i[0] = 32'h0050_0093;  addi_imm[0] = 64'd5;                 // addi x1,x0,5
        addi_i[1] = 32'hFFF0_0113;  addi_imm[1] = 64'hFFFF_FFFF_FFFF_FFFF; // addi x2,x0,-1
        addi_i[2] = 32'h7FF0_8193;  addi_imm[2] = 64'h7FF;               // addi x3,x1,2047
        addi_pc[0] = 64'h8000_0000;
        addi_pc[1] = 64'h8000_0004;
        addi_pc[2] = 64'h8000_0008;

        // Reset held over two edges, released between edges.
        repeat (2) @(posedge clk);
        #3 reset_n = 1'b1;
        @(negedge clk);
        check("post_rst_f_ready", f_ready, 1);
        tick();

        // Three ADDIs streamed with d_ready high.
        d_ready = 1'b1;
        offer(addi_i[0], addi_pc[0], OP_ALUI);
        tick();
        for (int i = 0; i < 3; i++) begin
            if (i < 2) offer(addi_i[i + 1], addi_pc[i + 1], OP_ALUI);
            else f_valid = 1'b0;
            @(negedge clk);
            check("stream_valid", d_valid, 1);
            check("stream_pc", d_pc, addi_pc[i]);
            check("stream_imm", d_imm, addi_imm[i]);
            tick();
        end
        @(negedge clk);
        check("stream_drained", state_dbg, 0);
        tick();

        // Back-pressure: two accepts fill the queue, third waits.
        d_ready = 1'b0;
        offer(32'h0010_0013, 64'h100, OP_ALUI);
        tick();
        offer(32'h0020_0013, 64'h104, OP_ALUI);
        tick();
        offer(32'h0030_0013, 64'h108, OP_ALUI);
        @(negedge clk);
        check("full_f_ready", f_ready, 0);
        check("full_state", state_dbg, 2);
        tick();
        d_ready = 1'b1;
        @(negedge clk);
        check("drain_a_pc", d_pc, 64'h100);
        tick();
        @(negedge clk);
        check("drain_b_pc", d_pc, 64'h104);
        check("leave_full_ready", f_ready, 1);
        tick();
        f_valid = 1'b0;
        @(negedge clk);
        check("drain_c_pc", d_pc, 64'h108);
        check("drain_c_state", state_dbg, 1);
        tick();
        @(negedge clk);
        check("bp_empty", state_dbg, 0);

        // Load-use: add x5,x6,x7 with LD to x6 in execute for 3 cycles.
        ex_load_valid = 1'b1;
        ex_rd = 5'd6;
        offer(32'h0073_02B3, 64'h200, OP_ALU);
        tick();
        f_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("hazard_d_valid", d_valid, 0);
            tick();
        end
        ex_rd = 5'd0;
        @(negedge clk);
        check("rd0_d_valid", d_valid, 1);
        check("stall_three", stall_cnt, 3);
        tick();
        ex_load_valid = 1'b0;
        @(negedge clk);
        check("stall_held", stall_cnt, 3);

        // Flush while FULL with an offer present.
        d_ready = 1'b0;
        offer(32'h0040_0013, 64'h300, OP_ALUI);
        tick();
        offer(32'h0050_0013, 64'h304, OP_ALUI);
        tick();
        offer(32'h0060_0013, 64'h308, OP_ALUI);
        flush = 1'b1;
        @(negedge clk);
        check("flush_state_before", state_dbg, 2);
        check("flush_d_valid", d_valid, 0);
        tick();
        flush = 1'b0;
        f_valid = 1'b0;
        @(negedge clk);
        check("flush_empty", state_dbg, 0);
        check("flush_f_ready", f_ready, 1);
        tick();

        // ONE with simultaneous enqueue and dequeue.
        d_ready = 1'b1;
        offer(32'h0070_0013, 64'h400, OP_ALUI);
        tick();
        offer(32'h0080_0013, 64'h404, OP_ALUI);
        @(negedge clk);
        check("one_head_x", d_pc, 64'h400);
        tick();
        f_valid = 1'b0;
        @(negedge clk);
        check("one_count", state_dbg, 1);
        check("one_head_y", d_pc, 64'h404);
        tick();

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            rand_inputs();
            tick();
        end

        // Asynchronous reset mid-stream.
        f_valid = 1'b0; ex_load_valid = 1'b0; d_ready = 1'b0; flush = 1'b1;
        tick();
        flush = 1'b0;
        offer(32'h0090_0013, 64'h500, OP_ALUI);
        tick();
        offer(32'h00A0_0013, 64'h504, OP_ALUI);
        tick();
        f_valid = 1'b1;
        #3 reset_n = 1'b0;
        #1;
        check("async_d_valid", d_valid, 0);
        check("async_f_ready", f_ready, 0);
        check("async_state", state_dbg, 0);
        check("async_stall", stall_cnt, 0);
        check("async_slot", d_instr, 0);
        f_valid = 1'b0;
        @(posedge clk);
        #3 reset_n = 1'b1;
        #1;
        check("rel_f_ready", f_ready, 1);
        d_ready = 1'b1;
        offer(32'h0640_0593, 64'h600, OP_ALUI);   // addi x11,x0,100
        tick();
        f_valid = 1'b0;
        @(negedge clk);
        check("rel_d_valid", d_valid, 1);
        check("rel_d_pc", d_pc, 64'h600);
        check("rel_d_imm", d_imm, 64'd100);
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
